arb_memory: RTL and testbench

//  Next-generation parametrised data memory with two ports sharing one array:

---
 rtl/arb_memory.sv | 171 +++++++++++++++++
 tb/tb_arb_memory.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_memory.sv
// ---------------------------------------------------------------------------
// arb_memory
//   Two-port data memory sharing a single array. Port A (CPU) and port B
//   (expansion) each use a req/gnt handshake; one access is performed per
//   cycle at the rising edge that ends the grant cycle. Reads are registered
//   and flagged with a one-cycle rvalid pulse.
//
//   Optional feature (macro MEM_CLEAR_EN): after reset the array is swept
//   with INIT_VAL, one word per cycle, while busy is held high and no
//   requests are granted.
//
// Parameters
//   ADDR_SIZE  address width (depth = 2**ADDR_SIZE words)
//   WIDTH      data word width
//   PRIO_MODE  0 = round-robin on conflict, 1 = port A always wins
//   INIT_VAL   word written by the clear sweep
//
// Ports
//   clk                        rising-edge clock
//   reset                      asynchronous, active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request, write flag, address, data
//   a_gnt                      port A request accepted this cycle
//   a_rvalid/a_rdata           port A read-data strobe / registered data
//   b_*                        same set for port B
//   busy                       array unavailable (clear sweep running)
// ---------------------------------------------------------------------------
module arb_memory #(
  parameter int unsigned      ADDR_SIZE = 11,
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      PRIO_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WIDTH-1:0]     a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WIDTH-1:0]     b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WIDTH-1:0]     b_rdata,
  output logic                 busy
);

  localparam int unsigned DEPTH = 2**ADDR_SIZE;

  logic [WIDTH-1:0]     mem_q [DEPTH];

  logic                 busy_w;
  logic                 clr_we;
  logic [ADDR_SIZE-1:0] clr_addr;

  logic                 a_win, b_win;
  logic                 last_b_q, last_b_d;
  logic                 a_rd, b_rd;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;

  logic                 a_rvalid_q, b_rvalid_q;
  logic [WIDTH-1:0]     a_rdata_q, b_rdata_q;

`ifdef MEM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == CLEAR) begin
      clr_we = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      // Last word is written on this edge; leave CLEAR together with it.
      if (cnt_q == '1) state_d = IDLE;
    end
  end

  assign busy_w   = (state_q == CLEAR);
  assign clr_addr = cnt_q;
`else
  assign busy_w   = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Arbitration: last_b_q remembers which port was granted most recently.
  always_comb begin
    a_win = a_req & ~busy_w;
    b_win = b_req & ~busy_w;
    if (a_win && b_win) begin
      if (PRIO_MODE != 0) b_win = 1'b0;
      else if (last_b_q)  b_win = 1'b0;
      else                a_win = 1'b0;
    end
    last_b_d = last_b_q;
    if (a_win)      last_b_d = 1'b0;
    else if (b_win) last_b_d = 1'b1;
  end

  assign a_gnt = a_win;
  assign b_gnt = b_win;
  assign a_rd  = a_win & ~a_we;
  assign b_rd  = b_win & ~b_we;

  // Single write path into the array: clear sweep or the granted port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = clr_addr;
    mem_wdata = INIT_VAL;
    if (clr_we) begin
      mem_we = 1'b1;
    end else if (a_win) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_win) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // Array contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_rd;
      if (a_rd) a_rdata_q <= mem_q[a_addr];
      if (b_rd) b_rdata_q <= mem_q[b_addr];
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = busy_w;

endmodule

// File: tb/tb_arb_memory.sv
// ---------------------------------------------------------------------------
// tb_arb_memory
//   Directed bench for arb_memory. Two instances share all inputs:
//   dut0 uses round-robin arbitration, dut1 gives port A fixed priority.
//   Inputs change on the falling edge; grants are sampled just after that,
//   registered outputs #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_arb_memory;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] IVAL = 16'h1234;

`ifdef MEM_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          a_gnt0, a_rvalid0, b_gnt0, b_rvalid0, busy0;
  logic [DW-1:0] a_rdata0, b_rdata0;
  logic          a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, busy1;
  logic [DW-1:0] a_rdata1, b_rdata1;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [DW-1:0] exp5;

  always #5 clk = ~clk;

  arb_memory #(.ADDR_SIZE(AW), .WIDTH(DW), .PRIO_MODE(0), .INIT_VAL(IVAL)) dut0 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
    .busy(busy0)
  );

  arb_memory #(.ADDR_SIZE(AW), .WIDTH(DW), .PRIO_MODE(1), .INIT_VAL(IVAL)) dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic br, input logic bw,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Bounded wait for the clear sweep (immediate in the default build).
  task automatic wait_ready();
    for (int n = 0; n < 64 && (busy0 || busy1); n++) @(negedge clk);
    check("sweep_done", {busy0, busy1}, 2'b00);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_rvalid", a_rvalid0, 1'b0);
    check("rst_b_rvalid", b_rvalid0, 1'b0);
    check("rst_a_rdata",  a_rdata0,  '0);
    check("rst_b_rdata",  b_rdata0,  '0);
    check("rst_busy",     busy0,     BUSY_RST);

    @(negedge clk);
    reset = 1'b1;
`ifdef MEM_CLEAR_EN
    // Request held from reset release; no grant until the sweep ends.
    drive(1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      #1;
      check("clr_busy", busy0, 1'b1);
      check("clr_no_gnt", a_gnt0, 1'b0);
      @(negedge clk);
    end
    #1;
    check("clr_busy_end", busy0, 1'b0);
    check("clr_gnt", a_gnt0, 1'b1);
    @(posedge clk); #1;
    check("clr_rvalid", a_rvalid0, 1'b1);
    check("clr_rdata", a_rdata0, IVAL);
    @(negedge clk);
    idle();
`endif

    // Test 1: writes addr i = 8-i, then reads back.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, AW'(i), DW'(8 - i), 1'b0, 1'b0, '0, '0);
      #1;
      check("t1_wr_gnt", a_gnt0, 1'b1);
      @(posedge clk); #1;
      check("t1_wr_no_rvalid", a_rvalid0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
      #1;
      check("t1_rd_gnt", a_gnt0, 1'b1);
      @(posedge clk); #1;
      check("t1_rvalid", a_rvalid0, 1'b1);
      check("t1_rdata", a_rdata0, DW'(8 - i));
    end
    @(negedge clk);
    idle();
    #1;
    check("t1_no_req_gnt", {a_gnt0, b_gnt0}, 2'b00);
    @(posedge clk); #1;
    check("t1_rvalid_drop", a_rvalid0, 1'b0);
    check("t1_rdata_hold", a_rdata0, 16'd1);

    // Test 2: read-after-write, same address, next cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd3, 16'hF00F, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd3, '0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check("t2_rvalid", a_rvalid0, 1'b1);
    check("t2_rdata", a_rdata0, 16'hF00F);

    // B-only write so the round-robin pointer last favours B.
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd9, 16'h0B0B);
    #1;
    check("b_only_gnt", b_gnt0, 1'b1);
    @(posedge clk); #1;
    check("b_wr_no_rvalid", b_rvalid0, 1'b0);

    // Tests 3/4: conflict held for 4 cycles. A reads addr 1 (7), B addr 2 (6).
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd1, '0, 1'b1, 1'b0, 4'd2, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_a_gnt", a_gnt0, (k % 2) == 0);
      check("t3_b_gnt", b_gnt0, (k % 2) == 1);
      check("t4_a_gnt", a_gnt1, 1'b1);
      check("t4_b_gnt", b_gnt1, 1'b0);
      @(posedge clk); #1;
      check("t3_a_rvalid", a_rvalid0, (k % 2) == 0);
      check("t3_b_rvalid", b_rvalid0, (k % 2) == 1);
      check("t4_b_rvalid", b_rvalid1, 1'b0);
      if (k == 0) check("t3_b_rdata_rst", b_rdata0, '0);
      if (k == 1) check("t3_b_rdata", b_rdata0, 16'd6);
      if (k == 2) check("t3_a_rdata", a_rdata0, 16'd7);
      if (k == 3) check("t4_a_rdata", a_rdata1, 16'd7);
      @(negedge clk);
    end
    a_req = 1'b0;
    #1;
    check("t4_b_gnt_after", b_gnt1, 1'b1);
    @(posedge clk); #1;
    check("t4_b_rvalid_after", b_rvalid1, 1'b1);
    check("t4_b_rdata_after", b_rdata1, 16'd6);

    // Test 5: reset asserted on the grant edge of a read.
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd5, 16'hAAAA, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0);
    #1;
    check("t5_gnt", a_gnt0, 1'b1);
    @(posedge clk);
    reset = 1'b0;
    idle();
    #1;
    check("t5_rvalid_drop", a_rvalid0, 1'b0);
    check("t5_rdata_rst", a_rdata0, '0);
    check("t5_b_rdata_rst", b_rdata1, '0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready();
`ifdef MEM_CLEAR_EN
    exp5 = IVAL;
`else
    exp5 = 16'hAAAA;
`endif
    // Re-read as a conflict: after reset A wins the first conflict.
    drive(1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd1, '0);
    #1;
    check("rr_first_a", a_gnt0, 1'b1);
    check("rr_first_b", b_gnt0, 1'b0);
    @(posedge clk); #1;
    check("t5_reread_rvalid", a_rvalid0, 1'b1);
    check("t5_reread_rdata", a_rdata0, exp5);
    @(negedge clk);
    idle();
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
